// File: rtl/ecc_scrubber.sv
// Background SECDED scrub controller for a 39-bit tc_sram bank; host traffic always wins the bank.
// Define ECC_SCRUBBER_STATS_EN to build the corrected/uncorrectable statistics counters.

module prim_secded_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);
    localparam logic [6:0][31:0] DataMask = {
        32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
        32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
    };

    always_comb begin
        data_o[31:0] = data_i;
        for (int unsigned j = 0; j < 7; j++) begin
            data_o[32 + j] = ^(data_i & DataMask[j]);
        end
    end
endmodule

module prim_secded_39_32_dec (
    input  logic [38:0] data_i,
    output logic [31:0] data_o,
    output logic [1:0]  err_o
);
    localparam logic [6:0][31:0] DataMask = {
        32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
        32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
    };

    logic [6:0] syndrome;

    always_comb begin
        for (int unsigned j = 0; j < 7; j++) begin
            syndrome[j] = (^(data_i[31:0] & DataMask[j])) ^ data_i[32 + j];
        end
    end

    // A data bit flips when the syndrome equals that bit's column of the parity matrix.
    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            data_o[i] = data_i[i] ^ (syndrome == {DataMask[6][i], DataMask[5][i], DataMask[4][i],
                                                  DataMask[3][i], DataMask[2][i], DataMask[1][i],
                                                  DataMask[0][i]});
        end
    end

    always_comb begin
        err_o[0] = ^syndrome;
        err_o[1] = ~(^syndrome) & (|syndrome);
    end
endmodule

module ecc_scrubber #(
    parameter  int unsigned BankSize      = 256,
    parameter  int unsigned ScrubInterval = 64,
    parameter  int unsigned CountWidth    = 16,
    localparam int unsigned BankAddWidth  = $clog2(BankSize)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    scrub_en_i,
    input  logic                    intc_req_i,
    input  logic                    intc_we_i,
    input  logic [BankAddWidth-1:0] intc_add_i,
    input  logic [38:0]             intc_wdata_i,
    output logic [38:0]             intc_rdata_o,
    output logic                    bank_req_o,
    output logic                    bank_we_o,
    output logic [BankAddWidth-1:0] bank_add_o,
    output logic [38:0]             bank_wdata_o,
    input  logic [38:0]             bank_rdata_i,
    output logic                    scrub_fix_o,
    output logic                    scrub_uncorrectable_o,
    output logic [CountWidth-1:0]   nb_corrected_o,
    output logic [CountWidth-1:0]   nb_uncorrectable_o
);
    localparam int unsigned IntWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRead    = 2'd1;
    localparam logic [1:0] StCheck   = 2'd2;
    localparam logic [1:0] StCorrect = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [BankAddWidth-1:0] addr_q, addr_d;
    logic [IntWidth-1:0]     cnt_q, cnt_d;
    logic [38:0]             fix_data_q, fix_data_d;

    logic [31:0] dec_data;
    logic [1:0]  dec_err;
    logic [38:0] enc_data;

    logic                    scrub_req;
    logic                    scrub_we;
    logic                    fix_pulse;
    logic                    unc_pulse;
    logic                    advance;
    logic                    host_hits;
    logic [BankAddWidth-1:0] addr_next;

    prim_secded_39_32_dec u_dec (
        .data_i (bank_rdata_i),
        .data_o (dec_data),
        .err_o  (dec_err)
    );

    prim_secded_39_32_enc u_enc (
        .data_i (dec_data),
        .data_o (enc_data)
    );

    assign host_hits = intc_req_i & intc_we_i & (intc_add_i == addr_q);
    assign addr_next = (addr_q == BankAddWidth'(BankSize - 1)) ? '0
                                                                : addr_q + BankAddWidth'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        fix_data_d = fix_data_q;
        scrub_req  = 1'b0;
        scrub_we   = 1'b0;
        fix_pulse  = 1'b0;
        unc_pulse  = 1'b0;
        advance    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!scrub_en_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IntWidth'(ScrubInterval - 1)) begin
                    cnt_d   = '0;
                    state_d = StRead;
                end else begin
                    cnt_d = cnt_q + IntWidth'(1);
                end
            end
            StRead: begin
                if (!scrub_en_i) begin
                    state_d = StIdle;
                end else if (!intc_req_i) begin
                    scrub_req = 1'b1;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                // A host write to the word under check makes the read result stale.
                if (host_hits) begin
                    advance = 1'b1;
                end else if (dec_err[1]) begin
                    unc_pulse = 1'b1;
                    advance   = 1'b1;
                end else if (dec_err[0]) begin
                    fix_data_d = enc_data;
                    state_d    = StCorrect;
                end else begin
                    advance = 1'b1;
                end
            end
            StCorrect: begin
                if (intc_req_i) begin
                    state_d = StRead;
                end else begin
                    scrub_req = 1'b1;
                    scrub_we  = 1'b1;
                    fix_pulse = 1'b1;
                    advance   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            addr_d  = addr_next;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            fix_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            fix_data_q <= fix_data_d;
        end
    end

    assign bank_req_o   = intc_req_i | scrub_req;
    assign bank_we_o    = intc_req_i ? intc_we_i    : scrub_we;
    assign bank_add_o   = intc_req_i ? intc_add_i   : addr_q;
    assign bank_wdata_o = intc_req_i ? intc_wdata_i : fix_data_q;
    assign intc_rdata_o = bank_rdata_i;

    assign scrub_fix_o           = fix_pulse;
    assign scrub_uncorrectable_o = unc_pulse;

`ifdef ECC_SCRUBBER_STATS_EN
    logic [CountWidth-1:0] nb_corr_q, nb_corr_d;
    logic [CountWidth-1:0] nb_unc_q, nb_unc_d;

    always_comb begin
        nb_corr_d = nb_corr_q;
        nb_unc_d  = nb_unc_q;
        if (fix_pulse && (nb_corr_q != '1)) begin
            nb_corr_d = nb_corr_q + CountWidth'(1);
        end
        if (unc_pulse && (nb_unc_q != '1)) begin
            nb_unc_d = nb_unc_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nb_corr_q <= '0;
            nb_unc_q  <= '0;
        end else begin
            nb_corr_q <= nb_corr_d;
            nb_unc_q  <= nb_unc_d;
        end
    end

    assign nb_corrected_o     = nb_corr_q;
    assign nb_uncorrectable_o = nb_unc_q;
`else
    assign nb_corrected_o     = '0;
    assign nb_uncorrectable_o = '0;
`endif
endmodule
